// File: rtl/pgm_pkg.sv
// Shared types and widths for the PGM packet scheduler.
package pgm_pkg;

    localparam int unsigned RAM_AW = 7;
    localparam int unsigned DW     = 134;
    localparam int unsigned RAM_DW = 144;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned GAP_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_READ = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Generation parameters captured on an accepted start
    typedef struct packed {
        logic [RAM_AW-1:0] last_addr;
        logic [CNT_W-1:0]  pkt_count;
        logic [GAP_W-1:0]  gap_cycles;
    } cfg_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pgm_sched_if.sv
// Control, RAM-read and packet-output signals of the PGM scheduler.
interface pgm_sched_if;
    import pgm_pkg::*;

    logic              start;
    logic              stop;
    logic [RAM_AW-1:0] last_addr;
    logic [CNT_W-1:0]  pkt_count;
    logic [GAP_W-1:0]  gap_cycles;
    logic              bypass_busy;
    logic              in_alf;
    logic              ram_rd_en;
    logic [RAM_AW-1:0] ram_addr;
    logic [RAM_DW-1:0] ram_rdata;
    logic [DW-1:0]     out_data;
    logic              out_data_wr;
    logic              out_valid;
    logic              out_valid_wr;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_cnt;

    modport master (
        output start, stop, last_addr, pkt_count, gap_cycles, bypass_busy, in_alf, ram_rdata,
        input  ram_rd_en, ram_addr, out_data, out_data_wr, out_valid, out_valid_wr,
               busy, done, sent_cnt
    );

    modport slave (
        input  start, stop, last_addr, pkt_count, gap_cycles, bypass_busy, in_alf, ram_rdata,
        output ram_rd_en, ram_addr, out_data, out_data_wr, out_valid, out_valid_wr,
               busy, done, sent_cnt
    );

endinterface

// File: rtl/pgm_gap_cnt.sv
// Loadable down-counter timing the idle gap between packets.
module pgm_gap_cnt
    import pgm_pkg::*;
#(
    parameter int unsigned W = GAP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pgm_sched.sv
// Replays a packet stored in PGM RAM pkt_count times (or until stop) with a
// programmable idle gap, yielding the output bus while bypass traffic is active.
module pgm_sched
    import pgm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    pgm_sched_if.slave bus
);

    state_e            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  sent_q, sent_d;
    logic              stop_flag_q, stop_flag_d;
    logic              rd_vld_q, rd_vld_d;
    logic              tail_q, tail_d;
    logic              done_q, done_d;

    logic              rd_go, rd_en, tail_rd, finish;
    logic              gap_load, gap_zero;
    logic [GAP_W-1:0]  gap_load_val;
    logic [CNT_W-1:0]  sent_inc;
    logic              unused_rdata_hi;

    // The first read is issued in the same cycle WAIT sees the bus free
    assign rd_go    = (state_q == ST_WAIT) && !bus.stop && !bus.bypass_busy && !bus.in_alf;
    assign rd_en    = rd_go || (state_q == ST_READ);
    assign tail_rd  = (state_q == ST_READ) && (addr_q == cfg_q.last_addr);
    assign sent_inc = sat_inc(sent_q);
    assign finish   = stop_flag_q || bus.stop ||
                      ((cfg_q.pkt_count != '0) && (sent_inc == cfg_q.pkt_count));
    assign gap_load_val = cfg_q.gap_cycles - GAP_W'(1);

    pgm_gap_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (gap_load_val),
        .tick     (state_q == ST_GAP),
        .zero     (gap_zero)
    );

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        addr_d      = addr_q;
        sent_d      = sent_q;
        stop_flag_d = stop_flag_q;
        done_d      = 1'b0;
        tail_d      = 1'b0;
        gap_load    = 1'b0;
        rd_vld_d    = rd_en;
        case (state_q)
            ST_IDLE: begin
                stop_flag_d = 1'b0;
                if (bus.start && !bus.stop && (bus.last_addr != '0)) begin
                    state_d = ST_WAIT;
                    sent_d  = '0;
                    cfg_d   = '{last_addr: bus.last_addr, pkt_count: bus.pkt_count,
                                gap_cycles: bus.gap_cycles};
                end
            end
            ST_WAIT: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (rd_go) begin
                    state_d = ST_READ;
                    addr_d  = RAM_AW'(1);
                end
            end
            ST_READ: begin
                addr_d = addr_q + RAM_AW'(1);
                if (bus.stop) stop_flag_d = 1'b1;
                if (tail_rd) begin
                    tail_d = 1'b1;
                    sent_d = sent_inc;
                    if (finish) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (cfg_q.gap_cycles == '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (gap_zero) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            addr_q      <= '0;
            sent_q      <= '0;
            stop_flag_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            tail_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            addr_q      <= addr_d;
            sent_q      <= sent_d;
            stop_flag_q <= stop_flag_d;
            rd_vld_q    <= rd_vld_d;
            tail_q      <= tail_d;
            done_q      <= done_d;
        end
    end

    // RAM data lands one cycle after the strobe; forward it only on valid cycles
    assign bus.ram_rd_en    = rd_en;
    assign bus.ram_addr     = (state_q == ST_READ) ? addr_q : '0;
    assign bus.out_data     = rd_vld_q ? bus.ram_rdata[DW-1:0] : '0;
    assign bus.out_data_wr  = rd_vld_q;
    assign bus.out_valid    = tail_q;
    assign bus.out_valid_wr = tail_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.sent_cnt     = sent_q;

    assign unused_rdata_hi = ^bus.ram_rdata[RAM_DW-1:DW];

endmodule

// File: tb/tb_pgm_sched.sv
// Scoreboard bench for pgm_sched: a RAM model feeds the DUT and every read and
// output word is matched against expectations queued when a run is started.
module tb_pgm_sched;
    import pgm_pkg::*;

    typedef logic [RAM_DW-1:0] cv_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          tail;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pgm_sched_if bus();

    pgm_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0]     mem [0:(1<<RAM_AW)-1];
    exp_t              exp_q[$];
    logic [RAM_AW-1:0] addr_exp_q[$];
    int                rd_cyc[$];
    int                n_chk = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                tail_cnt = 0;
    int                done_cnt = 0;

    task automatic chk(input string tag, input cv_t act, input cv_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model with junk in the upper bits
    always @(posedge clk) begin
        if (bus.ram_rd_en === 1'b1) bus.ram_rdata <= {10'h2b5, mem[bus.ram_addr]};
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.ram_rd_en) begin
            rd_cyc.push_back(cyc);
            if (addr_exp_q.size() == 0) chk("rd_unexp", cv_t'(bus.ram_rd_en), '0);
            else chk("ram_addr", cv_t'(bus.ram_addr), cv_t'(addr_exp_q.pop_front()));
        end
        if (bus.out_data_wr) begin
            if (exp_q.size() == 0) begin
                chk("word_unexp", cv_t'(bus.out_data_wr), '0);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", cv_t'(bus.out_data), cv_t'(e.data));
                chk("out_valid", cv_t'(bus.out_valid), cv_t'(e.tail));
                chk("out_valid_wr", cv_t'(bus.out_valid_wr), cv_t'(e.tail));
            end
            if (bus.out_valid_wr) tail_cnt++;
        end else begin
            chk("idle_out", cv_t'({bus.out_data, bus.out_valid, bus.out_valid_wr}), '0);
        end
        if (bus.done) done_cnt++;
    end

    task automatic push_pkts(input int last, input int n);
        for (int p = 0; p < n; p++) begin
            for (int a = 0; a <= last; a++) begin
                exp_q.push_back('{data: mem[a], tail: (a == last)});
                addr_exp_q.push_back(RAM_AW'(a));
            end
        end
    endtask

    task automatic start_gen(input int last, input int pkts, input int gap, output int s);
        @(posedge clk); #1;
        bus.last_addr  = RAM_AW'(last);
        bus.pkt_count  = CNT_W'(pkts);
        bus.gap_cycles = GAP_W'(gap);
        bus.start      = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int c);
        c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (bus.done) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk(tag, cv_t'(bus.done), cv_t'(1));
    endtask

    task automatic wait_rd(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rd_cyc.size() < n; i++) begin
            @(negedge clk); #1;
        end
        if (rd_cyc.size() < n) chk(tag, cv_t'(rd_cyc.size()), cv_t'(n));
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c, x, t0, d0;
        bit hit;
        bus.start = 1'b0; bus.stop = 1'b0; bus.last_addr = '0; bus.pkt_count = '0;
        bus.gap_cycles = '0; bus.bypass_busy = 1'b0; bus.in_alf = 1'b0;
        for (int i = 0; i < (1 << RAM_AW); i++)
            mem[i] = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", cv_t'(bus.busy), '0);
        chk("rst_done", cv_t'(bus.done), '0);
        chk("rst_sent", cv_t'(bus.sent_cnt), '0);
        chk("rst_rd", cv_t'(bus.ram_rd_en), '0);
        chk("rst_wr", cv_t'(bus.out_data_wr), '0);
        rst_n = 1'b1;

        // Two packets of four words with a four-cycle gap
        rd_cyc.delete();
        push_pkts(3, 2);
        start_gen(3, 2, 4, s);
        wait_done("t1_done", 200, c);
        chk("t1_sent", cv_t'(bus.sent_cnt), cv_t'(2));
        chk("t1_done_tail", cv_t'(bus.out_valid_wr), cv_t'(1));
        chk("t1_busy", cv_t'(bus.busy), '0);
        chk("t1_tails", cv_t'(tail_cnt), cv_t'(2));
        chk("t1_nrd", cv_t'(rd_cyc.size()), cv_t'(8));
        if (rd_cyc.size() == 8) begin
            chk("t1_first", cv_t'(rd_cyc[0]), cv_t'(s + 1));
            chk("t1_contig", cv_t'(rd_cyc[3] - rd_cyc[0]), cv_t'(3));
            chk("t1_gap", cv_t'(rd_cyc[4] - rd_cyc[3]), cv_t'(5));
            chk("t1_done_cyc", cv_t'(c), cv_t'(rd_cyc[7] + 1));
        end
        chk("t1_q", cv_t'(exp_q.size()), '0);

        // Bypass holds the first read until the cycle it drops
        repeat (2) @(posedge clk);
        rd_cyc.delete();
        bus.bypass_busy = 1'b1;
        push_pkts(2, 1);
        start_gen(2, 1, 0, s);
        repeat (9) @(posedge clk);
        #1;
        bus.bypass_busy = 1'b0;
        x = cyc;
        wait_done("t2_done", 100, c);
        chk("t2_nrd", cv_t'(rd_cyc.size()), cv_t'(3));
        if (rd_cyc.size() > 0) chk("t2_rise", cv_t'(rd_cyc[0]), cv_t'(x));
        chk("t2_sent", cv_t'(bus.sent_cnt), cv_t'(1));

        // Continuous mode, stop in the middle of the second packet
        repeat (2) @(posedge clk);
        rd_cyc.delete();
        push_pkts(5, 2);
        start_gen(5, 0, 2, s);
        wait_rd("t3_rd", 9, 100);
        pulse_stop();
        wait_done("t3_done", 100, c);
        chk("t3_sent", cv_t'(bus.sent_cnt), cv_t'(2));
        chk("t3_nrd", cv_t'(rd_cyc.size()), cv_t'(12));
        if (rd_cyc.size() == 12) chk("t3_done_cyc", cv_t'(c), cv_t'(rd_cyc[11] + 1));
        repeat (20) @(negedge clk);
        #1;
        chk("t3_idle_rd", cv_t'(rd_cyc.size()), cv_t'(12));
        chk("t3_busy", cv_t'(bus.busy), '0);

        // Rejected starts: zero-length packet, and start together with stop
        rd_cyc.delete();
        start_gen(0, 1, 0, s);
        @(negedge clk); #1;
        chk("t4_busy", cv_t'(bus.busy), '0);
        chk("t4_state", cv_t'(dut.state_q), cv_t'(ST_IDLE));
        @(posedge clk); #1;
        bus.last_addr = RAM_AW'(3);
        bus.start = 1'b1;
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        @(negedge clk); #1;
        chk("t4_ss_busy", cv_t'(bus.busy), '0);
        repeat (5) @(negedge clk);
        chk("t4_nrd", cv_t'(rd_cyc.size()), '0);

        // Reset while reading address 2 truncates the packet
        rd_cyc.delete();
        push_pkts(6, 1);
        start_gen(6, 0, 0, s);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.ram_rd_en && (bus.ram_addr == RAM_AW'(2))) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!hit) chk("t5_addr2", cv_t'(bus.ram_addr), cv_t'(2));
        t0 = tail_cnt;
        d0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        addr_exp_q.delete();
        @(negedge clk); #1;
        chk("t5_data", cv_t'(bus.out_data), '0);
        chk("t5_ctl", cv_t'({bus.ram_rd_en, bus.ram_addr, bus.out_data_wr, bus.out_valid,
                             bus.out_valid_wr, bus.busy, bus.done, bus.sent_cnt}), '0);
        chk("t5_state", cv_t'(dut.state_q), cv_t'(ST_IDLE));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("t5_tail", cv_t'(tail_cnt), cv_t'(t0));
        chk("t5_done", cv_t'(done_cnt), cv_t'(d0));

        // in_alf ignored inside a packet, honoured at the next WAIT
        rd_cyc.delete();
        push_pkts(4, 2);
        start_gen(4, 2, 0, s);
        x = s + 1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            bus.in_alf = k[0];
        end
        @(posedge clk); #1;
        bus.in_alf = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("t6_hold", cv_t'(rd_cyc.size()), cv_t'(5));
        if (rd_cyc.size() >= 5) chk("t6_contig", cv_t'(rd_cyc[4] - rd_cyc[0]), cv_t'(4));
        @(posedge clk); #1;
        bus.in_alf = 1'b0;
        @(negedge clk); #1;
        if (rd_cyc.size() > 5) chk("t6_resume", cv_t'(rd_cyc[5]), cv_t'(x + 10));
        else chk("t6_resume_n", cv_t'(rd_cyc.size()), cv_t'(6));
        wait_done("t6_done", 100, c);
        chk("t6_sent", cv_t'(bus.sent_cnt), cv_t'(2));

        // Stop during the gap ends generation on the next cycle
        repeat (2) @(posedge clk);
        rd_cyc.delete();
        push_pkts(1, 1);
        start_gen(1, 0, 8, s);
        t0 = tail_cnt;
        for (int i = 0; i < 50 && tail_cnt == t0; i++) begin
            @(negedge clk); #1;
        end
        chk("t7_tail", cv_t'(tail_cnt), cv_t'(t0 + 1));
        @(posedge clk); #1;
        bus.stop = 1'b1;
        x = cyc;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        wait_done("t7_done", 20, c);
        chk("t7_done_cyc", cv_t'(c), cv_t'(x + 1));
        chk("t7_sent", cv_t'(bus.sent_cnt), cv_t'(1));
        repeat (12) @(negedge clk);
        #1;
        chk("t7_nrd", cv_t'(rd_cyc.size()), cv_t'(2));
        chk("t7_q", cv_t'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pgm_sched.md
PGM_SCHED -- requirements
Module: pgm_sched

Interface
REQ-001 clk  in  1  single clock; all logic on its rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 start  in  1  one-cycle pulse: stored packet in PGM RAM is complete.
REQ-004 stop  in  1  one-cycle pulse: end generation after the current packet.
REQ-005 last_addr  in  7  RAM address of the stored packet's tail word.
REQ-006 pkt_count  in  32  packets to send; 0 = continuous until stop.
REQ-007 gap_cycles  in  16  idle cycles between consecutive packets.
REQ-008 bypass_busy  in  1  bypass packet occupies the output bus.
REQ-009 in_alf  in  1  downstream almost-full.
REQ-010 ram_rd_en  out  1  RAM read strobe; read data returns one cycle later.
REQ-011 ram_addr  out  7  RAM read address.
REQ-012 ram_rdata  in  144  RAM read data; bits [133:0] carry the packet word.
REQ-013 out_data  out  134  generated packet word.
REQ-014 out_data_wr  out  1  out_data valid.
REQ-015 out_valid  out  1  packet-valid flag; asserted together with out_valid_wr.
REQ-016 out_valid_wr  out  1  strobe for out_valid; asserted on the tail word.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse when generation ends.
REQ-019 sent_cnt  out  32  packets emitted since the last accepted start.

Function
REQ-020 FSM states: IDLE, WAIT, READ, GAP. Encodings: IDLE=0, WAIT=1, READ=2, GAP=3.
REQ-021 IDLE -> WAIT: start=1 and last_addr>=1; sent_cnt clears to 0 in the same cycle. start with last_addr=0 is ignored.
REQ-022 Parameters last_addr, pkt_count and gap_cycles are latched on the accepted start.
REQ-023 WAIT -> READ: first cycle with bypass_busy=0 and in_alf=0. ram_addr=0 and ram_rd_en=1 are issued in that same cycle.
REQ-024 READ: ram_addr increments by 1 each cycle through the latched last_addr. ram_rd_en stays high throughout; no gaps, no stall.
REQ-025 Latency: each out_data word (ram_rdata[133:0]) and out_data_wr=1 follow their ram_rd_en by exactly 1 cycle.
REQ-026 On the tail word: out_valid=1 and out_valid_wr=1 in the same cycle, and sent_cnt increments.
REQ-027 bypass_busy and in_alf are sampled only in WAIT; a packet in flight is never aborted.
REQ-028 After the tail read:
- stop has been seen, or pkt_count!=0 and the incremented sent_cnt==pkt_count: go to IDLE and pulse done on the tail-word output cycle.
- Otherwise, gap_cycles=0: go to WAIT.
- Otherwise: go to GAP.
REQ-029 GAP: count gap_cycles cycles, then go to WAIT. stop in GAP or WAIT goes to IDLE next cycle and pulses done.
REQ-030 stop during READ is held in a sticky flag. The flag clears in IDLE.
REQ-031 start when not in IDLE is ignored.
REQ-032 sent_cnt saturates at 0xFFFFFFFF.
REQ-033 start and stop in the same IDLE cycle: stop wins; remain in IDLE.
REQ-034 When out_data_wr=0: out_data=0, out_valid=0, out_valid_wr=0.

Reset
REQ-035 When rst_n=0 at a clock edge, the following all clear to 0:
- state (IDLE), sent_cnt, gap counter, stop flag, latched parameters;
- every output.
REQ-036 Reset in the middle of a packet truncates it. No tail word is emitted and done is not pulsed.

Structure
REQ-037 Package pgm_pkg holds:
- state encodings;
- widths RAM_AW=7, DW=134, RAM_DW=144.
REQ-038 The gap/packet counting logic is one sub-module, pgm_gap_cnt: load, tick, zero flag. Everything else stays flat.

Verification
REQ-039 last_addr=3, pkt_count=2, gap_cycles=4, start:
- reads at addresses 0-3 twice, with 4 idle cycles between the packets;
- two tail strobes; done with sent_cnt=2.
REQ-040 bypass_busy high for 10 cycles after start: ram_rd_en first rises in the cycle bypass_busy falls.
REQ-041 pkt_count=0, stop mid-packet: the current packet completes, then IDLE with a done pulse; no further reads.
REQ-042 start with last_addr=0: state stays IDLE, busy=0.
REQ-043 rst_n low at address 2 of a packet: all outputs are 0 next cycle and state is IDLE.
REQ-044 in_alf toggled during READ: word stream uninterrupted; in_alf=1 at the next WAIT holds the next packet.
